// File: rtl/unidade_controle_rodadas.sv
// unidade_controle_rodadas: Moore FSM for the memory game with progressive rounds and a per-play timeout.
module unidade_controle_rodadas #(
    parameter int TIMEOUT = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimE,
    input  logic       enderecoIgualL,
    input  logic       fimL,
    input  logic       modo,
    input  logic       timeout_en,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMO        = 4'h6,
        PROXIMA_RODADA = 4'h7,
        ESGOTADO       = 4'hC,
        ERROU          = 4'hD,
        ACERTOU        = 4'hF
    } estado_t;

    estado_t       estado, proximo;
    logic [TW-1:0] tcnt;
    logic          modo_q, tmo_en_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo;
    end

    // tcnt only counts while staying in ESPERA, so every play gets a fresh budget
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tcnt     <= '0;
            modo_q   <= 1'b0;
            tmo_en_q <= 1'b0;
        end else begin
            tcnt <= (estado == ESPERA && proximo == ESPERA) ? tcnt + TW'(1) : '0;
            if (estado == PREPARACAO) begin
                modo_q   <= modo;
                tmo_en_q <= timeout_en;
            end
        end
    end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:        proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     proximo = INICIA_RODADA;
            INICIA_RODADA:  proximo = ESPERA;
            ESPERA:         proximo = jogada ? REGISTRA :
                                      (tmo_en_q && tcnt == TW'(TIMEOUT - 1)) ? ESGOTADO : ESPERA;
            REGISTRA:       proximo = COMPARACAO;
            COMPARACAO:     proximo = !igual ? ERROU :
                                      !modo_q ? (fimE ? ACERTOU : PROXIMO) :
                                      !enderecoIgualL ? PROXIMO :
                                      fimL ? ACERTOU : PROXIMA_RODADA;
            PROXIMO:        proximo = ESPERA;
            PROXIMA_RODADA: proximo = INICIA_RODADA;
            ESGOTADO:       proximo = iniciar ? PREPARACAO : ESGOTADO;
            ERROU:          proximo = iniciar ? PREPARACAO : ERROU;
            ACERTOU:        proximo = iniciar ? PREPARACAO : ACERTOU;
            default:        proximo = INICIAL;
        endcase
    end

    always_comb begin
        zeraE     = estado inside {INICIAL, PREPARACAO, INICIA_RODADA};
        zeraL     = estado inside {INICIAL, PREPARACAO};
        zeraR     = estado inside {INICIAL, PREPARACAO};
        contaE    = estado == PROXIMO;
        contaL    = estado == PROXIMA_RODADA;
        registraR = estado == REGISTRA;
        acertou   = estado == ACERTOU;
        errou     = estado == ERROU;
        timeout   = estado == ESGOTADO;
        pronto    = estado inside {ACERTOU, ERROU, ESGOTADO};
        db_estado = estado inside {INICIAL, PREPARACAO, INICIA_RODADA, ESPERA, REGISTRA, COMPARACAO,
                                   PROXIMO, PROXIMA_RODADA, ESGOTADO, ERROU, ACERTOU} ? estado : 4'hE;
    end
endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// tb_unidade_controle_rodadas: directed checks of the round controller against a 4-address datapath model.
module tb_unidade_controle_rodadas;
    logic       clock = 1'b0, reset = 1'b1;
    logic       iniciar = 1'b0, jogada = 1'b0, modo = 1'b0, timeout_en = 1'b0;
    logic       igual, fimE, enderecoIgualL, fimL;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic       acertou, errou, timeout, pronto;
    logic [3:0] db_estado;
    int         e = 0, l = 0;
    logic       err_en = 1'b0;
    int         err_e = 0, err_l = 0;
    int         checks = 0, passed = 0;
    int         n_ce, n_cl, n_rr;

    unidade_controle_rodadas #(.TIMEOUT(8)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
        .fimE(fimE), .enderecoIgualL(enderecoIgualL), .fimL(fimL), .modo(modo),
        .timeout_en(timeout_en), .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL),
        .contaL(contaL), .zeraR(zeraR), .registraR(registraR), .acertou(acertou),
        .errou(errou), .timeout(timeout), .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Datapath model: play counter E, round counter L, injectable wrong play
    always @(posedge clock) begin
        if (zeraE) e <= 0; else if (contaE) e <= e + 1;
        if (zeraL) l <= 0; else if (contaL) l <= l + 1;
    end
    assign fimE           = (e == 3);
    assign fimL           = (l == 3);
    assign enderecoIgualL = (e == l);
    assign igual          = !(err_en && e == err_e && l == err_l);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    // Answers every ESPERA with a one-cycle jogada until a final state, counting output pulses
    task automatic play_game();
        int cyc = 0;
        n_ce = 0; n_cl = 0; n_rr = 0;
        while (!pronto && cyc < 400) begin
            n_ce += int'(contaE);
            n_cl += int'(contaL);
            n_rr += int'(registraR);
            jogada = (db_estado == 4'h3);
            step();
            cyc++;
        end
        jogada = 1'b0;
        chk("game_budget", 32'(cyc < 400), 1);
    endtask

    initial begin
        step(2);
        chk("rst_estado", 32'(db_estado), 0);
        chk("rst_zeras", {29'd0, zeraE, zeraL, zeraR}, 3'b111);
        chk("rst_others", {26'd0, contaE, contaL, registraR, acertou, errou, timeout}, 0);
        reset = 1'b0;
        step();
        chk("idle_hold", 32'(db_estado), 0);

        // fixed full sequence, all correct
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("m0_prep", 32'(db_estado), 1);
        play_game();
        chk("m0_end", 32'(db_estado), 4'hF);
        chk("m0_flags", {29'd0, acertou, pronto, errou}, 3'b110);
        chk("m0_contaE", n_ce, 3);
        chk("m0_contaL", n_cl, 0);
        chk("m0_registraR", n_rr, 4);

        // progressive rounds, all correct
        modo = 1'b1;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("m1_prep", 32'(db_estado), 1);
        play_game();
        chk("m1_end", 32'(db_estado), 4'hF);
        chk("m1_contaL", n_cl, 3);
        chk("m1_contaE", n_ce, 6);
        chk("m1_registraR", n_rr, 10);

        // progressive, wrong second play of round 2
        err_en = 1'b1; err_l = 2; err_e = 1;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        play_game();
        chk("err_end", 32'(db_estado), 4'hD);
        chk("err_flags", {29'd0, errou, pronto, acertou}, 3'b110);
        chk("err_registraR", n_rr, 5);
        chk("err_contaL", n_cl, 2);
        err_en = 1'b0;
        step(3);
        chk("err_hold", 32'(db_estado), 4'hD);
        iniciar = 1'b1;
        modo = 1'b0;
        timeout_en = 1'b1;
        step();
        iniciar = 1'b0;
        chk("err_restart", 32'(db_estado), 1);

        // timeout: ESPERA entered, ESGOTADO 8 cycles later
        step();
        chk("to_inicia", 32'(db_estado), 2);
        chk("to_zeraE", 32'(zeraE), 1);
        step();
        chk("to_espera", 32'(db_estado), 3);
        step(7);
        chk("to_cycle8", 32'(db_estado), 3);
        step();
        chk("to_esgotado", 32'(db_estado), 4'hC);
        chk("to_flags", {29'd0, timeout, pronto, acertou}, 3'b110);

        // timeout disabled: stays in ESPERA
        timeout_en = 1'b0;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step(2);
        chk("nto_espera", 32'(db_estado), 3);
        step(20);
        chk("nto_hold", 32'(db_estado), 3);
        chk("nto_timeout", 32'(timeout), 0);

        // asynchronous reset mid-ESPERA
        #1 reset = 1'b1;
        #1;
        chk("arst_estado", 32'(db_estado), 0);
        chk("arst_zeras", {28'd0, zeraE, zeraL, zeraR, timeout}, 4'b1110);
        step();
        reset = 1'b0;

        // jogada on the last allowed cycle beats the timeout; iniciar ignored in ESPERA
        timeout_en = 1'b1;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step(2);
        chk("late_espera", 32'(db_estado), 3);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("ign_iniciar", 32'(db_estado), 3);
        step(6);
        chk("late_cycle8", 32'(db_estado), 3);
        jogada = 1'b1;
        step();
        jogada = 1'b0;
        chk("late_registra", 32'(db_estado), 4);
        chk("late_registraR", 32'(registraR), 1);
        step();
        chk("late_compara", 32'(db_estado), 5);
        step();
        chk("late_proximo", 32'(db_estado), 6);
        chk("late_contaE", 32'(contaE), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
